// File: rtl/sprite_pkg.sv
// Shared widths and arbiter state encoding for the sprite ROM read port.
// Imported by the arbiter and its round-robin picker.
package sprite_pkg;

    localparam int SPRITE_ADDR_W  = 10;
    localparam int SPRITE_DATA_W  = 8;
    localparam int NUM_SPRITE_REQ = 4;

    typedef enum logic {
        ARB_RR     = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping.
// Purely combinational; returns a one-hot grant or zero.
module rr_pick
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = NUM_SPRITE_REQ,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among NUM_REQ requesters with
// round-robin arbitration, capped lock bursts and a tagged read pipeline.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = NUM_SPRITE_REQ,
    parameter int ADDR_W    = SPRITE_ADDR_W,
    parameter int DATA_W    = SPRITE_DATA_W,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] vpipe [ROM_LAT+1];

    logic               hold;
    logic [PTR_W-1:0]   search_ptr;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   gidx;
    logic               any;

    // While locked, ptr names the owner; losing the lock resumes after it.
    assign hold       = (state == ARB_LOCKED) && req[ptr] && lock[ptr];
    assign search_ptr = (state == ARB_LOCKED) ? nxt(ptr) : ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (search_ptr),
        .gnt (pick)
    );

    always_comb begin
        gnt = '0;
        if (reset_n) begin
            if (hold)
                gnt[ptr] = 1'b1;
            else
                gnt = pick;
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i])
                gidx = PTR_W'(i);
    end

    assign any = |gnt;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_RR;
            ptr      <= '0;
            cnt      <= '0;
            rom_addr <= '0;
        end else begin
            if (hold) begin
                if (cnt == CNT_W'(MAX_BURST - 1)) begin
                    state <= ARB_RR;
                    ptr   <= nxt(ptr);
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (any) begin
                if (lock[gidx] && MAX_BURST > 1) begin
                    state <= ARB_LOCKED;
                    ptr   <= gidx;
                    cnt   <= CNT_W'(1);
                end else begin
                    state <= ARB_RR;
                    ptr   <= nxt(gidx);
                    cnt   <= '0;
                end
            end else begin
                state <= ARB_RR;
                ptr   <= search_ptr;
                cnt   <= '0;
            end
            if (any)
                rom_addr <= req_addr[gidx*ADDR_W +: ADDR_W];
        end
    end

    // One-hot requester tags ride alongside the ROM read latency.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= ROM_LAT; k++)
                vpipe[k] <= '0;
        end else begin
            vpipe[0] <= gnt;
            for (int k = 1; k <= ROM_LAT; k++)
                vpipe[k] <= vpipe[k-1];
        end
    end

    assign rsp_valid = vpipe[ROM_LAT];
    assign rsp_data  = rom_q;

endmodule
